// File: rtl/sync_ram_bank.sv
// Parametrised synchronous data memory for the Processor load/store ports:
// byte strobes, pipelined reads with valid/error flags, write-first forwarding, optional zero-fill.
module sync_ram_bank #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned RD_LAT         = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r_enable,
    input  logic [ADDR_W-1:0]     r_addr,
    output logic [DATA_W-1:0]     r_data,
    output logic                  r_valid,
    output logic                  r_err,
    input  logic                  w_enable,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_strobe,
    output logic                  ready
);

    localparam int unsigned       NBYTES    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    logic [DATA_W-1:0] ram [DEPTH];

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              ready_next;
    logic              clear_we_c;

    logic              w_in_range;
    logic              r_in_range;
    logic              wr_accept;
    logic              rd_accept;
    logic              fwd_hit;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] rd_word;

    // Pipeline stage registers; the last stage drives the read outputs.
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_e;
    logic [DATA_W-1:0] pipe_d [RD_LAT];
    logic [RD_LAT-1:0] in_v;
    logic [RD_LAT-1:0] in_e;
    logic [DATA_W-1:0] in_d [RD_LAT];

    // State register for the clear/ready controller.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RESET_STATE;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            ready <= ready_next;
        end
    end

    // Clear walks ptr up to the last word, then hands over to READY.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        ready_next = 1'b0;
        clear_we_c = 1'b0;
        case (state)
            S_CLEAR: begin
                clear_we_c = 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_next = S_READY;
                    ready_next = 1'b1;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                end
            end
            S_READY: ready_next = 1'b1;
            default: state_next = RESET_STATE;
        endcase
    end

    for (genvar b = 0; b < NBYTES; b++) begin : g_mask
        assign wr_mask[b*8 +: 8] = {8{w_strobe[b]}};
    end

    assign w_in_range = {1'b0, w_addr} < DEPTH_X;
    assign r_in_range = {1'b0, r_addr} < DEPTH_X;
    assign wr_accept  = rst & ready & w_enable & w_in_range & (|w_strobe);
    assign rd_accept  = ready & r_enable;
    assign fwd_hit    = wr_accept & (w_addr == r_addr);

    // Read word as seen after this edge's write (write-first); out-of-range reads return zero.
    always_comb begin
        rd_raw = '0;
        if (r_in_range) begin
            rd_raw = ram[r_addr];
        end
        rd_word = rd_raw;
        if (fwd_hit) begin
            rd_word = (rd_raw & ~wr_mask) | (w_data & wr_mask);
        end
    end

    // Storage is never reset; zero-fill happens only through the CLEAR walk.
    always_ff @(posedge clk) begin
        if (rst && clear_we_c) begin
            ram[ptr] <= '0;
        end else if (wr_accept) begin
            ram[w_addr] <= (ram[w_addr] & ~wr_mask) | (w_data & wr_mask);
        end
    end

    for (genvar s = 0; s < RD_LAT; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign in_v[s] = rd_accept;
            assign in_e[s] = ~r_in_range;
            assign in_d[s] = rd_word;
        end else begin : g_tail
            assign in_v[s] = pipe_v[s-1];
            assign in_e[s] = pipe_e[s-1];
            assign in_d[s] = pipe_d[s-1];
        end

        // Data only advances with a valid token so the output holds between results.
        always_ff @(posedge clk) begin
            if (!rst) begin
                pipe_v[s] <= 1'b0;
                pipe_e[s] <= 1'b0;
                pipe_d[s] <= '0;
            end else begin
                pipe_v[s] <= in_v[s];
                pipe_e[s] <= in_v[s] & in_e[s];
                if (in_v[s]) begin
                    pipe_d[s] <= in_d[s];
                end
            end
        end
    end

    assign r_valid = pipe_v[RD_LAT-1];
    assign r_err   = pipe_e[RD_LAT-1];
    assign r_data  = pipe_d[RD_LAT-1];

endmodule

// File: tb/tb_sync_ram_bank.sv
// Directed bench for sync_ram_bank: an 8-bit zero-filling instance with single-cycle reads
// and a 32-bit, 10-word, 4-cycle-latency instance whose contents survive reset.
module tb_sync_ram_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_W=8, DEPTH=16, RD_LAT=1, CLEAR_ON_RESET=1
    logic       a_rst, a_re, a_rv, a_rerr, a_we, a_ready;
    logic [3:0] a_ra, a_wa;
    logic [7:0] a_rd, a_wd;
    logic [0:0] a_ws;

    // Instance B: DATA_W=32, DEPTH=10, RD_LAT=4, CLEAR_ON_RESET=0
    logic        b_rst, b_re, b_rv, b_rerr, b_we, b_ready;
    logic [3:0]  b_ra, b_wa;
    logic [31:0] b_rd, b_wd;
    logic [3:0]  b_ws;

    sync_ram_bank #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst(a_rst),
        .r_enable(a_re), .r_addr(a_ra), .r_data(a_rd), .r_valid(a_rv), .r_err(a_rerr),
        .w_enable(a_we), .w_addr(a_wa), .w_data(a_wd), .w_strobe(a_ws),
        .ready(a_ready)
    );

    sync_ram_bank #(.DATA_W(32), .ADDR_W(4), .DEPTH(10), .RD_LAT(4), .CLEAR_ON_RESET(0)) u_b (
        .clk(clk), .rst(b_rst),
        .r_enable(b_re), .r_addr(b_ra), .r_data(b_rd), .r_valid(b_rv), .r_err(b_rerr),
        .w_enable(b_we), .w_addr(b_wa), .w_data(b_wd), .w_strobe(b_ws),
        .ready(b_ready)
    );

    typedef struct packed {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       ws;
        logic       re;
        logic [3:0] ra;
        logic       ev;
        logic [7:0] ed;
        logic       ee;
    } vec_t;

    vec_t tbl [10];
    int   total  = 0;
    int   passed = 0;
    int   n;
    logic seen;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_read(input string nm, input logic [3:0] addr, input logic [7:0] ed);
        a_re = 1'b1;
        a_ra = addr;
        tick();
        a_re = 1'b0;
        check({nm, "_valid"}, a_rv, 1);
        check({nm, "_data"}, a_rd, ed);
        check({nm, "_err"}, a_rerr, 0);
    endtask

    // Waits (bounded) for B's r_valid; lat is the number of edges already seen since sampling.
    task automatic b_collect(input string nm, input int lat0, input logic [31:0] ed, input logic ee);
        int lat;
        lat = lat0;
        while (!b_rv && lat < 12) begin
            tick();
            lat++;
        end
        check({nm, "_lat"}, lat, 4);
        check({nm, "_data"}, b_rd, ed);
        check({nm, "_err"}, b_rerr, ee);
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        b_we = 1'b1;
        b_wa = addr;
        b_wd = data;
        b_ws = strb;
        tick();
        b_we = 1'b0;
    endtask

    task automatic b_read(input string nm, input logic [3:0] addr, input logic [31:0] ed, input logic ee);
        b_re = 1'b1;
        b_ra = addr;
        tick();
        b_re = 1'b0;
        b_collect(nm, 1, ed, ee);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        //                 we    wa     wd     ws    re    ra     ev    ed     ee
        tbl[0] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'hF, 1'b1, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 4'h2, 8'h7E, 1'b1, 1'b1, 4'h2, 1'b1, 8'h7E, 1'b0};
        tbl[3] = '{1'b1, 4'h3, 8'h62, 1'b1, 1'b0, 4'h0, 1'b0, 8'h7E, 1'b0};
        tbl[4] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h3, 1'b1, 8'h62, 1'b0};
        tbl[5] = '{1'b1, 4'h3, 8'h11, 1'b0, 1'b1, 4'h3, 1'b1, 8'h62, 1'b0};
        tbl[6] = '{1'b1, 4'h4, 8'hA5, 1'b1, 1'b1, 4'h2, 1'b1, 8'h7E, 1'b0};
        tbl[7] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h4, 1'b1, 8'hA5, 1'b0};
        tbl[8] = '{1'b1, 4'h2, 8'h33, 1'b1, 1'b1, 4'h2, 1'b1, 8'h33, 1'b0};
        tbl[9] = '{1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 8'h33, 1'b0};

        a_rst = 1'b0; a_re = 1'b0; a_ra = '0; a_we = 1'b0; a_wa = '0; a_wd = '0; a_ws = '0;
        b_rst = 1'b0; b_re = 1'b0; b_ra = '0; b_we = 1'b0; b_wa = '0; b_wd = '0; b_ws = '0;
        tick();
        check("a_rst_ready", a_ready, 0);
        check("a_rst_valid", a_rv, 0);
        check("a_rst_data", a_rd, 0);
        check("a_rst_err", a_rerr, 0);
        check("b_rst_ready", b_ready, 0);
        check("b_rst_valid", b_rv, 0);
        check("b_rst_data", b_rd, 0);

        // Zero-fill: requests issued while ready=0 must be dropped.
        a_rst = 1'b1;
        a_we = 1'b1; a_wa = 4'h0; a_wd = 8'h99; a_ws = 1'b1;
        a_re = 1'b1; a_ra = 4'h0;
        n = 0;
        seen = 1'b0;
        while (!a_ready && n < 40) begin
            tick();
            n++;
            seen = seen | a_rv;
        end
        a_we = 1'b0;
        a_re = 1'b0;
        check("a_clear_len", n, 16);
        check("a_no_valid_in_clear", seen, 0);

        for (int i = 0; i < 10; i++) begin
            a_we = tbl[i].we; a_wa = tbl[i].wa; a_wd = tbl[i].wd; a_ws = tbl[i].ws;
            a_re = tbl[i].re; a_ra = tbl[i].ra;
            tick();
            check($sformatf("a_vec%0d_valid", i), a_rv, tbl[i].ev);
            check($sformatf("a_vec%0d_data", i), a_rd, tbl[i].ed);
            check($sformatf("a_vec%0d_err", i), a_rerr, tbl[i].ee);
        end
        a_we = 1'b0;
        a_re = 1'b0;

        for (int i = 5; i < 16; i++) begin
            a_read($sformatf("a_zero%0d", i), 4'(i), 8'h00);
        end

        // Reset in READY re-clears; a second reset at ptr=7 restarts the walk from 0.
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1;
        repeat (7) tick();
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1;
        n = 0;
        while (!a_ready && n < 40) begin
            tick();
            n++;
        end
        check("a_reclear_len", n, 16);
        a_read("a_reclr4", 4'h4, 8'h00);
        a_read("a_reclr2", 4'h2, 8'h00);

        // Instance B, contents kept across reset.
        b_rst = 1'b1;
        tick();
        check("b_ready_after_reset", b_ready, 1);

        b_write(4'h5, 32'h11223344, 4'hF);
        b_write(4'h5, 32'hAABBCCDD, 4'b0101);
        b_read("b_strobe", 4'h5, 32'h11BB33DD, 1'b0);

        b_write(4'h2, 32'h22222222, 4'hF);
        b_write(4'h9, 32'h00000099, 4'hF);
        b_write(4'hC, 32'hFFFFFFFF, 4'hF);
        b_read("b_oor", 4'hC, 32'h0, 1'b1);
        b_read("b_nowrap", 4'h2, 32'h22222222, 1'b0);
        b_read("b_last", 4'h9, 32'h00000099, 1'b0);

        // Write one edge after the read is sampled must not affect it.
        b_re = 1'b1; b_ra = 4'h2;
        tick();
        b_re = 1'b0;
        b_we = 1'b1; b_wa = 4'h2; b_wd = 32'h0000007E; b_ws = 4'hF;
        tick();
        b_we = 1'b0;
        b_collect("b_war", 2, 32'h22222222, 1'b0);
        b_read("b_war_after", 4'h2, 32'h0000007E, 1'b0);

        // Same-edge read and strobed write: merged word returned.
        b_re = 1'b1; b_ra = 4'h5;
        b_we = 1'b1; b_wa = 4'h5; b_wd = 32'hFFFFFFFF; b_ws = 4'b1010;
        tick();
        b_re = 1'b0;
        b_we = 1'b0;
        b_collect("b_fwd", 1, 32'hFFBBFFDD, 1'b0);

        // Back-to-back reads complete on consecutive cycles.
        b_re = 1'b1;
        b_ra = 4'h5; tick();
        b_ra = 4'h2; tick();
        b_ra = 4'h9; tick();
        b_re = 1'b0;
        tick();
        check("b_b2b0_valid", b_rv, 1);
        check("b_b2b0_data", b_rd, 32'hFFBBFFDD);
        tick();
        check("b_b2b1_valid", b_rv, 1);
        check("b_b2b1_data", b_rd, 32'h0000007E);
        tick();
        check("b_b2b2_valid", b_rv, 1);
        check("b_b2b2_data", b_rd, 32'h00000099);
        tick();
        check("b_b2b_idle_valid", b_rv, 0);
        check("b_b2b_hold_data", b_rd, 32'h00000099);

        // Reset with three reads in flight: none may complete.
        b_re = 1'b1;
        b_ra = 4'h5; tick();
        b_ra = 4'h2; tick();
        b_ra = 4'h9; tick();
        b_re = 1'b0;
        b_rst = 1'b0;
        tick();
        check("b_midrst_valid", b_rv, 0);
        check("b_midrst_data", b_rd, 0);
        b_rst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | b_rv;
        end
        check("b_discard", seen, 0);
        b_read("b_survive", 4'h5, 32'hFFBBFFDD, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sync_ram_bank.md
Name: sync_ram_bank

Overview:
- Parametrised synchronous data memory. It is the next generation of the 8-bit/16-word Ram used with the Processor core.
- Adds configurable width and depth, byte-write strobes, a read-latency pipeline with a valid flag, and write-first read-during-write forwarding.
- Adds out-of-range error reporting and an optional post-reset zero-fill state machine with a ready flag.
- Sits between the Processor load/store ports and storage. The Processor must honour r_valid and ready.

Parameters:
- DATA_W, 8: word width in bits. Must be a multiple of 8.
- ADDR_W, 4: address width in bits.
- DEPTH, 16: number of words. Must satisfy 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1: read latency in cycles. Legal range 1..4.
- CLEAR_ON_RESET, 1: 1 = zero-fill all words after reset; 0 = contents survive reset, which permits hierarchical preload of ram[].

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst, in, 1: synchronous active-low reset, sampled on posedge clk.
- r_enable, in, 1: read request.
- r_addr, in, ADDR_W: read address.
- r_data, out, DATA_W: read data.
- r_valid, out, 1: r_data carries the result of one request this cycle.
- r_err, out, 1: the request now completing used an address >= DEPTH. Aligned with r_valid.
- w_enable, in, 1: write request.
- w_addr, in, ADDR_W: write address.
- w_data, in, DATA_W: write data.
- w_strobe, in, DATA_W/8: per-byte write enable. Bit i covers w_data[8i+7:8i].
- ready, out, 1: block accepts requests.

Behaviour:
- Reset (rst=0 at a posedge):
  - Outputs: r_data=0, r_valid=0, r_err=0, ready=0.
  - All read-pipeline stages are invalidated.
  - Clear pointer set to 0.
  - Next state is CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - Storage is untouched by reset itself.
- FSM has two states, CLEAR and READY.
  - CLEAR: each cycle writes 0 to ram[ptr] and increments ptr. The edge that writes ptr=DEPTH-1 moves the FSM to READY, so CLEAR lasts exactly DEPTH cycles.
  - READY: ready=1. The FSM stays in READY until reset.
- Gating: requests are sampled only when ready=1 at the edge. Requests while ready=0 are dropped: no storage change, no r_valid.
- Read timing:
  - A request sampled at edge N has r_data/r_valid/r_err visible after edge N+RD_LAT-1.
  - RD_LAT=1 gives data in the cycle following the request cycle.
  - The pipeline is fully pipelined: one new read per cycle, and r_valid pulses once per accepted request.
  - When r_valid=0, r_data holds its last value.
- Write: at the edge, ram[w_addr] takes w_data for bytes whose strobe bit is 1; other bytes keep their old value. w_strobe=0 performs no write.
- Read-during-write:
  - Same address at the same edge is write-first: the read returns the merged post-write word.
  - Different addresses are independent.
  - A write after a read's sampling edge does not affect that read, even if RD_LAT>1.
- Out of range (addr >= DEPTH):
  - Write is dropped.
  - Read completes normally with r_data=0 and r_err=1.
  - No wrap-around: the address is never taken modulo DEPTH.
- Reset mid-operation:
  - In-flight reads are discarded; no r_valid is emitted for them.
  - Reset during CLEAR restarts the clear from ptr=0.
  - Reset during READY with CLEAR_ON_RESET=1 re-clears all words.
- Width rules:
  - Strobe merge is bytewise.
  - ptr is ADDR_W bits and cannot overflow, because it stops at DEPTH-1.
  - DEPTH=2**ADDR_W is legal, and r_err is then never set.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16: hold rst=0 for 1 cycle, release -> ready=0 for 16 cycles, then 1; reading addresses 0..15 returns 0x00 with r_err=0.
- CLEAR_ON_RESET=0, RD_LAT=1, preload ram[0..6]={41,55,13,62,01,02,00}: read addr 3 -> r_data=0x62 with r_valid 1 cycle later; back-to-back reads of 0,1,2 -> 41,55,13 on consecutive cycles.
- DATA_W=32, addr 5 holds 0x11223344: write w_data=0xAABBCCDD, w_strobe=4'b0101 -> subsequent read returns 0x11BB33DD.
- Same-edge write 0x7E to addr 2 and read of addr 2 -> r_data=0x7E. With RD_LAT=3, a write to addr 2 one edge after the read -> that read still returns the old value.
- DEPTH=10, ADDR_W=4: write 0xFF to addr 12 -> contents unchanged; read addr 12 -> r_data=0, r_err=1, r_valid=1; read addr 9 -> r_err=0.
- RD_LAT=4, issue reads at 3 consecutive edges, assert rst=0 on the next edge -> no r_valid afterwards. Assert rst=0 again when ptr=7 during CLEAR -> ready rises exactly 16 cycles after release.
